nios_system_hbridge_drive: RTL and testbench
============================================

// Module: nios_system_hbridge_drive
// PURPOSE
//  Consumes the 1-bit direction level from the reverse PIO plus a duty word and drives the two
//  H-bridge inputs of one DC motor. Generates PWM locally and enforces a dead interval on every
//  direction change, so the high and low legs never cross-conduct.
//  Sits between the Nios PIO outputs and the motor-driver pins.
// PARAMETERS
//  PWM_BITS         8     width of duty and PWM counter; PWM period = PRESCALE * 2**PWM_BITS clk
//  PRESCALE         10    clk cycles per PWM count step (>=1)
//  DEADTIME_CYCLES  5000  clk cycles both legs are held inactive on reversal (>=1, <2**DT_W)
//  DT_W             16    dead-time counter width
// PORTS
//  clk         in   1         system clock
//  reset_n     in   1         asynchronous active-low reset
//  reverse_in  in   1         requested direction, 0 = forward, 1 = reverse; same clock domain
//  enable      in   1         1 = PWM allowed; 0 = forced off (direction FSM keeps running)
//  duty        in   PWM_BITS  on-count per PWM period
//  hb_in1      out  1         bridge input 1 (forward leg)
//  hb_in2      out  1         bridge input 2 (reverse leg)
//  busy        out  1         1 while in DEAD
//  dir_out     out  1         direction currently applied (0 fwd, 1 rev)
// BEHAVIOUR
//  Reset: hb_in1 = hb_in2 = busy = dir_out = 0; state = FWD; all counters = 0; duty_q = 0.
//  Prescaler: pre_cnt runs 0..PRESCALE-1; tick = (pre_cnt == PRESCALE-1).
//  On tick, pwm_cnt increments mod 2**PWM_BITS.
//  duty_q <= duty when tick && pwm_cnt == max (at the period boundary). No mid-period update.
//  pwm_on = enable && (pwm_cnt < duty_q), unsigned compare.
//  duty=0 gives always off; duty=max gives on for (2**PWM_BITS-1)/2**PWM_BITS of the period.
//  FSM states: FWD, REV, DEAD.
//   FWD: reverse_in=1 -> DEAD, dt_cnt <= DEADTIME_CYCLES-1.
//   REV: reverse_in=0 -> DEAD, dt_cnt <= DEADTIME_CYCLES-1.
//   DEAD: dt_cnt decrements each clk.
//     At dt_cnt==0, exit to REV if reverse_in=1, else to FWD.
//     reverse_in toggling during DEAD is ignored until exit; the interval is never restarted
//     or shortened.
//   dir_out updates on the DEAD exit edge only, and holds its previous value during DEAD.
//   DEAD lasts exactly DEADTIME_CYCLES clk cycles.
//  Outputs are registered, 1 clk after state/pwm_on:
//   FWD:  hb_in1 = pwm_on, hb_in2 = 0
//   REV:  hb_in1 = 0, hb_in2 = pwm_on
//   DEAD: both 0 (see CONFIGURATION)
//  Invariant: hb_in1 && hb_in2 is never 1 unless NIOS_HBRIDGE_BRAKE_EN is defined and the
//   state is DEAD.
//  A request equal to the current direction never enters DEAD, and a glitch-free level has no
//   effect.
//  Reset asserted mid-DEAD or mid-period: outputs drop to 0 asynchronously and the FSM restarts
//   in FWD.
//  After reset release, reverse_in=1 takes the full dead interval before REV drives.
// CONFIGURATION
//  NIOS_HBRIDGE_BRAKE_EN defined: in DEAD, hb_in1 = hb_in2 = enable (low-side brake).
//   Registered with the same 1-clk latency.
//  Undefined: DEAD drives both 0 (coast). No other behaviour differs.
// STRUCTURE
//  Package nios_system_hbridge_pkg: state enum {FWD, REV, DEAD}, 2-bit encoding, DIR_FWD/DIR_REV.
//  Sub-module nios_system_pwm_gen: prescaler, pwm_cnt, duty_q latch, pwm_on output.
//  Top level holds the FSM, dt_cnt and the output registers.
// TESTING (bench uses PWM_BITS=4, PRESCALE=1, DEADTIME_CYCLES=4)
//  1. Reset, enable=1, duty=4, reverse_in=0 -> hb_in1 high 4 of every 16 clk, hb_in2 always 0.
//  2. Toggle reverse_in 0->1 -> busy=1 for exactly 4 clk with both outputs 0.
//     Then dir_out=1 and hb_in2 carries PWM.
//  3. During DEAD, pulse reverse_in 1->0->1 -> still exactly 4 clk DEAD, then exits to REV.
//  4. Change duty 4->12 mid-period -> current period keeps 4 on-counts, next period has 12.
//     duty=0 gives no pulses; duty=15 gives 15/16 on.
//  5. enable=0 in FWD with duty=8 -> both outputs 0.
//     Reversal still runs DEAD and sets dir_out=1.
//  6. Assert reset_n mid-DEAD -> outputs 0 immediately; after release state is FWD.
//     Build with NIOS_HBRIDGE_BRAKE_EN: scenario 2 shows both outputs 1 for 4 clk.
//  The in1&&in2 invariant is checked every cycle in all runs.

Source files
------------

// File: rtl/nios_system_hbridge_pkg.sv
// Shared state encoding and direction constants for the H-bridge drive.
package nios_system_hbridge_pkg;

    typedef enum logic [1:0] {
        FWD  = 2'd0,
        REV  = 2'd1,
        DEAD = 2'd2
    } hb_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/nios_system_pwm_gen.sv
// Purpose: prescaled PWM counter with period-boundary duty latch; pwm_on gated by enable.
// Latency: pwm_on is combinational from the registered counter and latched duty.
// Backpressure: none, free-running.
module nios_system_pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_q;
    logic                tick;

    assign tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                // duty only moves at the wrap so a period is never truncated or stretched
                if (&pwm_cnt) begin
                    duty_q <= duty;
                end
            end
        end
    end

    assign pwm_on = enable && (pwm_cnt < duty_q);

endmodule

// File: rtl/nios_system_hbridge_drive.sv
// Purpose: direction FSM with dead interval plus PWM steering onto the two bridge legs (brake in DEAD with NIOS_HBRIDGE_BRAKE_EN).
// Latency: hb_in1/hb_in2 registered, 1 clk after state and pwm_on.
// Backpressure: none; reversal requests are absorbed while busy and honoured at DEAD exit.
module nios_system_hbridge_drive
    import nios_system_hbridge_pkg::*;
#(
    parameter int PWM_BITS        = 8,
    parameter int PRESCALE        = 10,
    parameter int DEADTIME_CYCLES = 5000,
    parameter int DT_W            = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                reverse_in,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] duty,
    output logic                hb_in1,
    output logic                hb_in2,
    output logic                busy,
    output logic                dir_out
);

    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYCLES - 1);

    hb_state_t       state;
    logic [DT_W-1:0] dt_cnt;
    logic            pwm_on;
    logic            dead_drive;

    nios_system_pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .duty    (duty),
        .pwm_on  (pwm_on)
    );

`ifdef NIOS_HBRIDGE_BRAKE_EN
    assign dead_drive = enable;
`else
    assign dead_drive = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FWD;
            dt_cnt  <= '0;
            busy    <= 1'b0;
            dir_out <= DIR_FWD;
            hb_in1  <= 1'b0;
            hb_in2  <= 1'b0;
        end else begin
            hb_in1 <= 1'b0;
            hb_in2 <= 1'b0;
            case (state)
                FWD: begin
                    hb_in1 <= pwm_on;
                    if (reverse_in) begin
                        state  <= DEAD;
                        dt_cnt <= DT_LOAD;
                        busy   <= 1'b1;
                    end
                end
                REV: begin
                    hb_in2 <= pwm_on;
                    if (!reverse_in) begin
                        state  <= DEAD;
                        dt_cnt <= DT_LOAD;
                        busy   <= 1'b1;
                    end
                end
                DEAD: begin
                    hb_in1 <= dead_drive;
                    hb_in2 <= dead_drive;
                    // reverse_in is only sampled here, so mid-interval toggles cannot restart it
                    if (dt_cnt == '0) begin
                        busy <= 1'b0;
                        if (reverse_in) begin
                            state   <= REV;
                            dir_out <= DIR_REV;
                        end else begin
                            state   <= FWD;
                            dir_out <= DIR_FWD;
                        end
                    end else begin
                        dt_cnt <= dt_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= FWD;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_hbridge_drive.sv
// Directed bench for the H-bridge drive: PWM_BITS=4, PRESCALE=1, DEADTIME_CYCLES=4.
module tb_nios_system_hbridge_drive;

`ifdef NIOS_HBRIDGE_BRAKE_EN
    localparam bit BRAKE = 1'b1;
`else
    localparam bit BRAKE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       reverse_in;
    logic       enable;
    logic [3:0] duty;
    logic       hb_in1;
    logic       hb_in2;
    logic       busy;
    logic       dir_out;

    int   tests = 0;
    int   fails = 0;
    logic prev_busy = 1'b0;

    always #5 clk = ~clk;

    nios_system_hbridge_drive #(
        .PWM_BITS        (4),
        .PRESCALE        (1),
        .DEADTIME_CYCLES (4),
        .DT_W            (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .reverse_in (reverse_in),
        .enable     (enable),
        .duty       (duty),
        .hb_in1     (hb_in1),
        .hb_in2     (hb_in2),
        .busy       (busy),
        .dir_out    (dir_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the no-cross-conduction invariant.
    // A brake build may drive both legs while DEAD is visible on the outputs (1 clk lag).
    task automatic step();
        @(negedge clk);
        if (reset_n === 1'b1 && !(BRAKE && (busy === 1'b1 || prev_busy === 1'b1)))
            check("no_cross", {31'd0, hb_in1 & hb_in2}, 0);
        prev_busy = busy;
    endtask

    task automatic count_hi(input int n, output int c1, output int c2);
        c1 = 0;
        c2 = 0;
        repeat (n) begin
            step();
            if (hb_in1 === 1'b1) c1++;
            if (hb_in2 === 1'b1) c2++;
        end
    endtask

    task automatic count_busy(input int n, output int c);
        c = 0;
        repeat (n) begin
            step();
            if (busy === 1'b1) c++;
        end
    endtask

    // Follows one dead interval: length, leg levels while DEAD is on the outputs, final direction.
    task automatic run_dead(input string tag, input bit glitch, input logic exp_dir);
        int   n;
        bit   done;
        logic e;
        e = BRAKE ? enable : 1'b0;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (busy === 1'b1) begin
                if (n >= 1) begin
                    check({tag, "_dead_in1"}, {31'd0, hb_in1}, {31'd0, e});
                    check({tag, "_dead_in2"}, {31'd0, hb_in2}, {31'd0, e});
                end
                if (glitch && n < 2) reverse_in = ~reverse_in;
                n++;
            end else if (n > 0) begin
                check({tag, "_last_in1"}, {31'd0, hb_in1}, {31'd0, e});
                check({tag, "_last_in2"}, {31'd0, hb_in2}, {31'd0, e});
                done = 1'b1;
            end
        end
        check({tag, "_busy_len"}, n, 4);
        check({tag, "_dir"}, {31'd0, dir_out}, {31'd0, exp_dir});
    endtask

    initial begin
        int   c1;
        int   c2;
        int   n;
        logic prev;
        bit   found;

        reset_n    = 1'b0;
        reverse_in = 1'b0;
        enable     = 1'b1;
        duty       = 4'd4;
        #12;
        check("rst_in1", {31'd0, hb_in1}, 0);
        check("rst_in2", {31'd0, hb_in2}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_dir", {31'd0, dir_out}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // forward PWM at duty 4
        repeat (20) step();
        count_hi(16, c1, c2);
        check("s1_in1_on", c1, 4);
        check("s1_in2_on", c2, 0);

        // reversal 0->1
        reverse_in = 1'b1;
        run_dead("s2", 1'b0, 1'b1);
        count_hi(16, c1, c2);
        check("s2_in1_on", c1, 0);
        check("s2_in2_on", c2, 4);
        count_busy(8, n);
        check("s2_same_dir_no_dead", n, 0);

        // back to forward, then reverse with a 1->0->1 pulse inside DEAD
        reverse_in = 1'b0;
        run_dead("s3_fwd", 1'b0, 1'b0);
        reverse_in = 1'b1;
        run_dead("s3_glitch", 1'b1, 1'b1);
        count_busy(8, n);
        check("s3_no_restart", n, 0);

        // duty 4 -> 12 one count into a period (reverse leg)
        prev = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (prev === 1'b0 && hb_in2 === 1'b1) found = 1'b1;
            else prev = hb_in2;
        end
        check("s4_period_sync", {31'd0, found}, 1);
        duty = 4'd12;
        c2 = 1;
        repeat (15) begin
            step();
            if (hb_in2 === 1'b1) c2++;
        end
        check("s4_old_period", c2, 4);
        count_hi(16, c1, c2);
        check("s4_new_period", c2, 12);

        duty = 4'd0;
        repeat (32) step();
        count_hi(16, c1, c2);
        check("s4_duty0", c2, 0);
        duty = 4'd15;
        repeat (32) step();
        count_hi(16, c1, c2);
        check("s4_duty15", c2, 15);

        // enable=0 forces both legs off; direction FSM still runs
        duty = 4'd8;
        enable = 1'b0;
        reverse_in = 1'b0;
        run_dead("s5_fwd", 1'b0, 1'b0);
        repeat (20) step();
        count_hi(16, c1, c2);
        check("s5_off_in1", c1, 0);
        check("s5_off_in2", c2, 0);
        reverse_in = 1'b1;
        run_dead("s5_rev", 1'b0, 1'b1);
        count_hi(16, c1, c2);
        check("s5_rev_in1", c1, 0);
        check("s5_rev_in2", c2, 0);

        // reset in the middle of DEAD
        enable = 1'b1;
        reverse_in = 1'b0;
        step();
        step();
        check("s6_in_dead", {31'd0, busy}, 1);
        reset_n = 1'b0;
        #1;
        check("s6_rst_in1", {31'd0, hb_in1}, 0);
        check("s6_rst_in2", {31'd0, hb_in2}, 0);
        check("s6_rst_busy", {31'd0, busy}, 0);
        check("s6_rst_dir", {31'd0, dir_out}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        check("s6_fwd_busy", {31'd0, busy}, 0);
        check("s6_fwd_dir", {31'd0, dir_out}, 0);
        reverse_in = 1'b1;
        run_dead("s6_rev", 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
